hps_axi3_to_axil_bridge: RTL



---
 rtl/hps_axi3_to_axil_bridge_if.sv | 99 +++++++++
 rtl/hps_axi3_to_axil_bridge.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hps_axi3_to_axil_bridge_if.sv
// hps_axi3_to_axil_bridge_if: AXI3 (HPS side) and AXI-lite (student side) signal bundle
// slave modport  : bridge view (accepts AXI3 from the HPS, masters AXI-lite)
// master modport : environment view (drives AXI3 requests, answers AXI-lite)
interface hps_axi3_to_axil_bridge_if #(
   parameter int ADDR_W = 21,
   parameter int ID_W   = 12,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]     s_awid;
   logic [ADDR_W-1:0]   s_awaddr;
   logic [3:0]          s_awlen;
   logic [1:0]          s_awburst;
   logic                s_awvalid;
   logic                s_awready;
   logic [DATA_W-1:0]   s_wdata;
   logic [DATA_W/8-1:0] s_wstrb;
   logic                s_wlast;
   logic                s_wvalid;
   logic                s_wready;
   logic [ID_W-1:0]     s_bid;
   logic [1:0]          s_bresp;
   logic                s_bvalid;
   logic                s_bready;
   logic [ID_W-1:0]     s_arid;
   logic [ADDR_W-1:0]   s_araddr;
   logic [3:0]          s_arlen;
   logic [1:0]          s_arburst;
   logic                s_arvalid;
   logic                s_arready;
   logic [ID_W-1:0]     s_rid;
   logic [DATA_W-1:0]   s_rdata;
   logic [1:0]          s_rresp;
   logic                s_rlast;
   logic                s_rvalid;
   logic                s_rready;
   logic [ADDR_W-1:0]   m_awaddr;
   logic                m_awvalid;
   logic                m_awready;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic                m_wvalid;
   logic                m_wready;
   logic [1:0]          m_bresp;
   logic                m_bvalid;
   logic                m_bready;
   logic [ADDR_W-1:0]   m_araddr;
   logic                m_arvalid;
   logic                m_arready;
   logic [DATA_W-1:0]   m_rdata;
   logic [1:0]          m_rresp;
   logic                m_rvalid;
   logic                m_rready;

   modport slave (
      input  s_awid, s_awaddr, s_awlen, s_awburst, s_awvalid,
      output s_awready,
      input  s_wdata, s_wstrb, s_wlast, s_wvalid,
      output s_wready,
      output s_bid, s_bresp, s_bvalid,
      input  s_bready,
      input  s_arid, s_araddr, s_arlen, s_arburst, s_arvalid,
      output s_arready,
      output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      input  s_rready,
      output m_awaddr, m_awvalid,
      input  m_awready,
      output m_wdata, m_wstrb, m_wvalid,
      input  m_wready,
      input  m_bresp, m_bvalid,
      output m_bready,
      output m_araddr, m_arvalid,
      input  m_arready,
      input  m_rdata, m_rresp, m_rvalid,
      output m_rready
   );

   modport master (
      output s_awid, s_awaddr, s_awlen, s_awburst, s_awvalid,
      input  s_awready,
      output s_wdata, s_wstrb, s_wlast, s_wvalid,
      input  s_wready,
      input  s_bid, s_bresp, s_bvalid,
      output s_bready,
      output s_arid, s_araddr, s_arlen, s_arburst, s_arvalid,
      input  s_arready,
      input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      output s_rready,
      input  m_awaddr, m_awvalid,
      output m_awready,
      input  m_wdata, m_wstrb, m_wvalid,
      output m_wready,
      output m_bresp, m_bvalid,
      input  m_bready,
      input  m_araddr, m_arvalid,
      output m_arready,
      output m_rdata, m_rresp, m_rvalid,
      input  m_rready
   );
endinterface

// File: rtl/hps_axi3_to_axil_bridge.sv
// hps_axi3_to_axil_bridge: splits HPS AXI3 bursts into single-beat AXI-lite transfers
// clk   : system clock
// rst_n : asynchronous active-low reset
// bus   : AXI3 slave port (s_*) and AXI-lite master port (m_*), slave modport
module hps_axi3_to_axil_bridge #(
   parameter int ADDR_W = 21,
   parameter int ID_W   = 12,
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic rst_n,
   hps_axi3_to_axil_bridge_if.slave bus
);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
   localparam logic [2:0] W_IDLE = 3'd0, W_DATA = 3'd1, W_ISSUE = 3'd2, W_WAIT = 3'd3, W_BRESP = 3'd4;
   localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_WAIT = 2'd2, R_SEND = 2'd3;

   function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
      return a > b ? a : b;
   endfunction

   logic [2:0]          w_state;
   logic [ID_W-1:0]     w_id;
   logic [ADDR_W-1:0]   w_addr;
   logic [3:0]          w_len, w_cnt;
   logic                w_fixed;
   logic [1:0]          w_resp;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                aw_v, w_v, aw_left, w_left;

   logic [1:0]          r_state;
   logic [ID_W-1:0]     r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_len, r_cnt;
   logic                r_fixed, r_err;
   logic [DATA_W-1:0]   r_data;
   logic [1:0]          r_resp;

   // AW and W complete independently; a channel stays pending until its own ready
   assign aw_left = aw_v & ~bus.m_awready;
   assign w_left  = w_v & ~bus.m_wready;

   assign bus.s_awready = w_state == W_IDLE;
   assign bus.s_wready  = w_state == W_DATA;
   assign bus.s_bvalid  = w_state == W_BRESP;
   assign bus.s_bid     = w_id;
   assign bus.s_bresp   = w_resp;
   assign bus.m_awaddr  = w_addr;
   assign bus.m_awvalid = aw_v;
   assign bus.m_wdata   = w_data;
   assign bus.m_wstrb   = w_strb;
   assign bus.m_wvalid  = w_v;
   assign bus.m_bready  = w_state == W_WAIT;

   assign bus.s_arready = r_state == R_IDLE;
   assign bus.s_rvalid  = r_state == R_SEND;
   assign bus.s_rid     = r_id;
   assign bus.s_rdata   = r_data;
   assign bus.s_rresp   = r_resp;
   assign bus.s_rlast   = r_state == R_SEND && r_cnt == r_len;
   assign bus.m_araddr  = r_addr;
   assign bus.m_arvalid = r_state == R_ADDR;
   assign bus.m_rready  = r_state == R_WAIT;

   // WRAP and reserved bursts run as INCR; starting the merged response at SLVERR flags them
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_fixed <= 1'b0;
         w_resp  <= OKAY;
         w_data  <= '0;
         w_strb  <= '0;
         aw_v    <= 1'b0;
         w_v     <= 1'b0;
      end else
         case (w_state)
            W_IDLE:
               if (bus.s_awvalid) begin
                  w_id    <= bus.s_awid;
                  w_addr  <= bus.s_awaddr;
                  w_len   <= bus.s_awlen;
                  w_fixed <= bus.s_awburst == 2'b00;
                  w_resp  <= bus.s_awburst[1] ? SLVERR : OKAY;
                  w_cnt   <= '0;
                  w_state <= W_DATA;
               end
            W_DATA:
               if (bus.s_wvalid) begin
                  w_data  <= bus.s_wdata;
                  w_strb  <= bus.s_wstrb;
                  if (bus.s_wlast != (w_cnt == w_len))
                     w_resp <= max2(w_resp, SLVERR);
                  aw_v    <= 1'b1;
                  w_v     <= 1'b1;
                  w_state <= W_ISSUE;
               end
            W_ISSUE: begin
               aw_v <= aw_left;
               w_v  <= w_left;
               if (!aw_left && !w_left)
                  w_state <= W_WAIT;
            end
            W_WAIT:
               if (bus.m_bvalid) begin
                  w_resp <= max2(w_resp, bus.m_bresp);
                  if (w_cnt == w_len)
                     w_state <= W_BRESP;
                  else begin
                     w_cnt   <= w_cnt + 4'd1;
                     w_addr  <= w_fixed ? w_addr : w_addr + STEP;
                     w_state <= W_DATA;
                  end
               end
            W_BRESP:
               if (bus.s_bready)
                  w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_fixed <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_resp  <= OKAY;
      end else
         case (r_state)
            R_IDLE:
               if (bus.s_arvalid) begin
                  r_id    <= bus.s_arid;
                  r_addr  <= bus.s_araddr;
                  r_len   <= bus.s_arlen;
                  r_fixed <= bus.s_arburst == 2'b00;
                  r_err   <= bus.s_arburst[1];
                  r_cnt   <= '0;
                  r_state <= R_ADDR;
               end
            R_ADDR:
               if (bus.m_arready)
                  r_state <= R_WAIT;
            R_WAIT:
               if (bus.m_rvalid) begin
                  r_data  <= bus.m_rdata;
                  r_resp  <= r_err ? max2(bus.m_rresp, SLVERR) : bus.m_rresp;
                  r_state <= R_SEND;
               end
            R_SEND:
               if (bus.s_rready) begin
                  if (r_cnt == r_len)
                     r_state <= R_IDLE;
                  else begin
                     r_cnt   <= r_cnt + 4'd1;
                     r_addr  <= r_fixed ? r_addr : r_addr + STEP;
                     r_state <= R_ADDR;
                  end
               end
            default: r_state <= R_IDLE;
         endcase
endmodule
